instr_encoder: RTL and testbench

//  Host-side builder of 32-bit MPU instruction words {op[31:28],id[27:26],row[25:23],col[22:20],

---
 rtl/mpu_isa_pkg.sv | 35 +++
 rtl/instr_encoder_if.sv | 30 +++
 rtl/instr_pack.sv | 30 +++
 rtl/instr_encoder.sv | 162 ++++++++++++++++
 tb/tb_instr_encoder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mpu_isa_pkg.sv
// MPU instruction-set definitions shared by the instruction encoder and decoder:
// field positions, opcodes, matrix geometry and the packed instruction word.
package mpu_isa_pkg;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 28;
  localparam int ID_MSB   = 27;
  localparam int ID_LSB   = 26;
  localparam int ROW_MSB  = 25;
  localparam int ROW_LSB  = 23;
  localparam int COL_MSB  = 22;
  localparam int COL_LSB  = 20;
  localparam int VAL_MSB  = 19;
  localparam int VAL_LSB  = 4;
  localparam int RSVD_MSB = 3;
  localparam int RSVD_LSB = 0;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_MAC   = 4'h3;

  localparam int MAT_DIM   = 5;
  localparam int MAT_ELEMS = MAT_DIM * MAT_DIM;

  typedef struct packed {
    logic [OP_MSB:OP_LSB]     op;
    logic [ID_MSB:ID_LSB]     id;
    logic [ROW_MSB:ROW_LSB]   row;
    logic [COL_MSB:COL_LSB]   col;
    logic [VAL_MSB:VAL_LSB]   values;
    logic [RSVD_MSB:RSVD_LSB] rsvd;
  } instr_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Host <-> encoder channels: command request, element stream and outgoing
// instruction words, each with its own valid/ready handshake.
interface instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [1:0]  req_id;
  logic [2:0]  req_row;
  logic [2:0]  req_col;
  logic [4:0]  req_len;
  logic [15:0] req_values;
  logic        elem_valid;
  logic        elem_ready;
  logic [7:0]  elem_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_word;

  modport master (
    output req_valid, req_op, req_id, req_row, req_col, req_len, req_values,
    output elem_valid, elem_data, ins_ready,
    input  req_ready, elem_ready, ins_valid, ins_word
  );

  modport slave (
    input  req_valid, req_op, req_id, req_row, req_col, req_len, req_values,
    input  elem_valid, elem_data, ins_ready,
    output req_ready, elem_ready, ins_valid, ins_word
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational packer of instruction fields into a 32-bit MPU word.
// INSTR_PARITY_EN: bit 0 carries even parity over the word; otherwise bits 3:0 are zero.
module instr_pack
  import mpu_isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  id,
  input  logic [2:0]  row,
  input  logic [2:0]  col,
  input  logic [15:0] values,
  output logic [31:0] word
);

  instr_t fields;

  // NOTE: every combinational output gets a full default first so no path can infer a latch.
  always_comb begin
    fields        = '0;
    fields.op     = op;
    fields.id     = id;
    fields.row    = row;
    fields.col    = col;
    fields.values = values;
    word          = fields;
`ifdef INSTR_PARITY_EN
    word[RSVD_LSB] = ^word[31:1];
`endif
  end

endmodule

// File: rtl/instr_encoder.sv
// Host-side MPU instruction builder: single-word commands plus burst writes that pack
// two element bytes per word while walking row/col across the matrix. Parity: INSTR_PARITY_EN.
module instr_encoder
  import mpu_isa_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  instr_encoder_if.slave  bus,
  output logic            busy,
  output logic            err
);

  typedef enum logic [1:0] {ST_IDLE, ST_GATHER_HI, ST_GATHER_LO, ST_EMIT} state_t;

  localparam logic [4:0] DIM5   = 5'(MAT_DIM);
  localparam logic [6:0] ELEMS7 = 7'(MAT_ELEMS);

  state_t      state;
  logic [3:0]  op_q;
  logic [1:0]  id_q;
  logic [2:0]  row_q;
  logic [2:0]  col_q;
  logic [7:0]  hi_q;
  logic [4:0]  rem_q;

  logic [3:0]  pk_op;
  logic [1:0]  pk_id;
  logic [2:0]  pk_row;
  logic [2:0]  pk_col;
  logic [15:0] pk_values;
  logic [31:0] word_next;
  logic [6:0]  p_end;
  logic        req_legal;
  logic [4:0]  col_sum;

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.elem_ready = (state == ST_GATHER_HI) || (state == ST_GATHER_LO);

  // Burst fits only if its last element still lies inside the matrix.
  assign p_end = 7'(bus.req_col) + 7'(bus.req_row) * 7'(MAT_DIM) + 7'(bus.req_len);

  always_comb begin
    req_legal = ({2'b00, bus.req_row} < DIM5) && ({2'b00, bus.req_col} < DIM5);
    if (bus.req_op == OP_WRITE)
      req_legal = req_legal && (bus.req_len != 5'd0) && (7'(bus.req_len) <= ELEMS7) &&
                  (p_end <= ELEMS7);
  end

  // Word contents are formed from whatever completes it this cycle, then registered.
  always_comb begin
    pk_op     = op_q;
    pk_id     = id_q;
    pk_row    = row_q;
    pk_col    = col_q;
    pk_values = {hi_q, bus.elem_data};
    case (state)
      ST_IDLE: begin
        pk_op     = bus.req_op;
        pk_id     = bus.req_id;
        pk_row    = bus.req_row;
        pk_col    = bus.req_col;
        pk_values = bus.req_values;
      end
      ST_GATHER_HI: pk_values = {bus.elem_data, 8'h00};
      default: ;
    endcase
  end

  instr_pack u_pack (
    .op     (pk_op),
    .id     (pk_id),
    .row    (pk_row),
    .col    (pk_col),
    .values (pk_values),
    .word   (word_next)
  );

  assign col_sum = {2'b00, col_q} + 5'd2;

  // NOTE: all state below is sequential and updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      op_q          <= '0;
      id_q          <= '0;
      row_q         <= '0;
      col_q         <= '0;
      hi_q          <= '0;
      rem_q         <= '0;
      bus.ins_valid <= 1'b0;
      bus.ins_word  <= '0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (!req_legal) begin
              err <= 1'b1;
            end else begin
              op_q  <= bus.req_op;
              id_q  <= bus.req_id;
              row_q <= bus.req_row;
              col_q <= bus.req_col;
              busy  <= 1'b1;
              if (bus.req_op == OP_WRITE) begin
                rem_q <= bus.req_len;
                state <= ST_GATHER_HI;
              end else begin
                rem_q         <= '0;
                bus.ins_word  <= word_next;
                bus.ins_valid <= 1'b1;
                state         <= ST_EMIT;
              end
            end
          end
        end
        ST_GATHER_HI: begin
          if (bus.elem_valid) begin
            hi_q  <= bus.elem_data;
            rem_q <= rem_q - 5'd1;
            if (rem_q == 5'd1) begin
              bus.ins_word  <= word_next;
              bus.ins_valid <= 1'b1;
              state         <= ST_EMIT;
            end else begin
              state <= ST_GATHER_LO;
            end
          end
        end
        ST_GATHER_LO: begin
          if (bus.elem_valid) begin
            rem_q         <= rem_q - 5'd1;
            bus.ins_word  <= word_next;
            bus.ins_valid <= 1'b1;
            state         <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (bus.ins_ready) begin
            bus.ins_valid <= 1'b0;
            if (col_sum >= DIM5) begin
              col_q <= 3'(col_sum - DIM5);
              row_q <= row_q + 3'd1;
            end else begin
              col_q <= col_sum[2:0];
            end
            if (rem_q != 5'd0) begin
              state <= ST_GATHER_HI;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: single ops, bursts with row wrap,
// legality rejects, output backpressure and asynchronous reset mid-burst.
module tb_instr_encoder;
  import mpu_isa_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic err;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int words    = 0;
  int w0;
  logic [31:0] exp_w;

  // Count accepted words; inputs only change just after posedge, so negedge sees the handshake.
  always @(negedge clk) if (rst_n && bus.ins_valid && bus.ins_ready) words++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Field layout {op,id,row,col,values,rsvd}, plus parity in the parity build.
  function automatic logic [31:0] exp_word(input logic [3:0] op, input logic [1:0] id,
                                           input logic [2:0] row, input logic [2:0] col,
                                           input logic [15:0] v);
    logic [31:0] w;
    w = {op, id, row, col, v, 4'b0000};
`ifdef INSTR_PARITY_EN
    w[0] = ^w[31:1];
`endif
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [3:0] op, input logic [1:0] id, input logic [2:0] row,
                          input logic [2:0] col, input logic [4:0] len, input logic [15:0] v);
    int t = 0;
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_id     = id;
    bus.req_row    = row;
    bus.req_col    = col;
    bus.req_len    = len;
    bus.req_values = v;
    while (!bus.req_ready && t < 50) begin
      step();
      t++;
    end
    if (!bus.req_ready) check("req_timeout", 32'd0, 32'd1);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic send_elem(input logic [7:0] d);
    int t = 0;
    bus.elem_valid = 1'b1;
    bus.elem_data  = d;
    while (!bus.elem_ready && t < 50) begin
      step();
      t++;
    end
    if (!bus.elem_ready) check("elem_timeout", 32'd0, 32'd1);
    step();
    bus.elem_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] exp);
    int t = 0;
    while (!bus.ins_valid && t < 50) begin
      step();
      t++;
    end
    check({tag, "_valid"}, 32'(bus.ins_valid), 32'd1);
    check(tag, bus.ins_word, exp);
    if (bus.ins_ready) step();
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_id     = '0;
    bus.req_row    = '0;
    bus.req_col    = '0;
    bus.req_len    = '0;
    bus.req_values = '0;
    bus.elem_valid = 1'b0;
    bus.elem_data  = '0;
    bus.ins_ready  = 1'b1;
    rst_n          = 1'b0;

    repeat (2) step();
    check("rst_ins_valid", 32'(bus.ins_valid), 32'd0);
    check("rst_ins_word", bus.ins_word, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Elements offered while idle must not be consumed.
    bus.elem_valid = 1'b1;
    bus.elem_data  = 8'hEE;
    repeat (3) begin
      step();
      check("idle_elem_ready", 32'(bus.elem_ready), 32'd0);
    end
    bus.elem_valid = 1'b0;

    // Scenario 1: single op; {3,2'b10,3'b001,3'b011} gives 0x38B in the top 12 bits.
    send_req(4'h3, 2'd2, 3'd1, 3'd3, 5'd0, 16'hBEEF);
    check("s1_latency", 32'(bus.ins_valid), 32'd1);
    check("s1_busy", 32'(busy), 32'd1);
`ifdef INSTR_PARITY_EN
    check("s1_word", bus.ins_word, 32'h38BBEEF1);
`else
    check("s1_word", bus.ins_word, 32'h38BBEEF0);
`endif
    step();
    check("s1_busy_drop", 32'(busy), 32'd0);
    check("s1_valid_drop", 32'(bus.ins_valid), 32'd0);

    // Scenario 2: five-element burst from (0,0).
    w0 = words;
    send_req(OP_WRITE, 2'd0, 3'd0, 3'd0, 5'd5, 16'h0000);
    send_elem(8'h11);
    send_elem(8'h22);
    expect_word("s2_w0", exp_word(4'h1, 2'd0, 3'd0, 3'd0, 16'h1122));
    send_elem(8'h33);
    send_elem(8'h44);
    expect_word("s2_w1", exp_word(4'h1, 2'd0, 3'd0, 3'd2, 16'h3344));
    send_elem(8'h55);
    expect_word("s2_w2", exp_word(4'h1, 2'd0, 3'd0, 3'd4, 16'h5500));
    repeat (3) step();
    check("s2_count", 32'(words - w0), 32'd3);
    check("s2_idle", 32'(busy), 32'd0);

    // Scenario 3: end of row, mid-pair row wrap, last cell, then illegal requests.
    send_req(OP_WRITE, 2'd3, 3'd0, 3'd4, 5'd2, 16'h0000);
    send_elem(8'hAA);
    send_elem(8'hBB);
    expect_word("s3_rowend", exp_word(4'h1, 2'd3, 3'd0, 3'd4, 16'hAABB));
    send_req(OP_WRITE, 2'd1, 3'd2, 3'd4, 5'd4, 16'h0000);
    send_elem(8'h01);
    send_elem(8'h02);
    expect_word("s3_wrap0", exp_word(4'h1, 2'd1, 3'd2, 3'd4, 16'h0102));
    send_elem(8'h03);
    send_elem(8'h04);
    expect_word("s3_wrap1", exp_word(4'h1, 2'd1, 3'd3, 3'd1, 16'h0304));
    send_req(OP_WRITE, 2'd2, 3'd4, 3'd4, 5'd1, 16'h0000);
    send_elem(8'h5A);
    expect_word("s3_last", exp_word(4'h1, 2'd2, 3'd4, 3'd4, 16'h5A00));

    w0 = words;
    send_req(OP_WRITE, 2'd0, 3'd4, 3'd4, 5'd2, 16'h0000);
    check("s3_overrun_err", 32'(err), 32'd1);
    check("s3_overrun_busy", 32'(busy), 32'd0);
    check("s3_overrun_ready", 32'(bus.req_ready), 32'd1);
    step();
    check("s3_err_pulse", 32'(err), 32'd0);
    send_req(4'h3, 2'd0, 3'd5, 3'd0, 5'd0, 16'h1234);
    check("s3_row5_err", 32'(err), 32'd1);
    send_req(OP_WRITE, 2'd0, 3'd0, 3'd0, 5'd0, 16'h0000);
    check("s3_len0_err", 32'(err), 32'd1);
    repeat (2) step();
    check("s3_no_words", 32'(words - w0), 32'd0);

    // Scenario 4: output backpressure with a pending element and a request while busy.
    bus.ins_ready = 1'b0;
    send_req(OP_WRITE, 2'd1, 3'd1, 3'd0, 5'd4, 16'h0000);
    send_elem(8'h01);
    send_elem(8'h02);
    exp_w = exp_word(4'h1, 2'd1, 3'd1, 3'd0, 16'h0102);
    w0 = words;
    bus.elem_valid = 1'b1;
    bus.elem_data  = 8'h03;
    bus.req_valid  = 1'b1;
    bus.req_op     = 4'h3;
    bus.req_row    = 3'd0;
    bus.req_col    = 3'd0;
    repeat (7) begin
      check("bp_valid", 32'(bus.ins_valid), 32'd1);
      check("bp_word", bus.ins_word, exp_w);
      check("bp_elem_ready", 32'(bus.elem_ready), 32'd0);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.req_valid = 1'b0;
    bus.ins_ready = 1'b1;
    step();
    check("bp_once", 32'(words - w0), 32'd1);
    send_elem(8'h03);
    send_elem(8'h04);
    expect_word("bp_w1", exp_word(4'h1, 2'd1, 3'd1, 3'd2, 16'h0304));
    repeat (2) step();
    check("bp_total", 32'(words - w0), 32'd2);
    check("bp_idle", 32'(busy), 32'd0);

    // Scenario 5: asynchronous reset while a word is pending mid-burst.
    send_req(OP_WRITE, 2'd0, 3'd0, 3'd0, 5'd6, 16'h0000);
    send_elem(8'hA1);
    send_elem(8'hA2);
    expect_word("s5_w0", exp_word(4'h1, 2'd0, 3'd0, 3'd0, 16'hA1A2));
    send_elem(8'hA3);
    bus.ins_ready = 1'b0;
    send_elem(8'hA4);
    check("s5_pending", 32'(bus.ins_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_async_valid", 32'(bus.ins_valid), 32'd0);
    check("s5_async_word", bus.ins_word, 32'd0);
    check("s5_async_busy", 32'(busy), 32'd0);
    w0 = words;
    bus.ins_ready = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("s5_no_partial", 32'(words - w0), 32'd0);
    send_req(4'h3, 2'd2, 3'd1, 3'd3, 5'd0, 16'hBEEF);
    expect_word("s5_after", exp_word(4'h3, 2'd2, 3'd1, 3'd3, 16'hBEEF));
    check("s5_after_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
